// File: rtl/pcont_perfcnt_pkg.sv
// Shared definitions for the performance-counter bank: event select codes,
// register map and control-field bit positions.
package pcont_perfcnt_pkg;

  typedef enum logic [3:0] {
    ESEL_NONE   = 4'd0,
    ESEL_CYCLE  = 4'd1,
    ESEL_INST   = 4'd2,
    ESEL_IMISS  = 4'd3,
    ESEL_ISTALL = 4'd4,
    ESEL_DMISS  = 4'd5,
    ESEL_DSTALL = 4'd6,
    ESEL_DLOAD  = 4'd7,
    ESEL_DSTORE = 4'd8,
    ESEL_DLDST  = 4'd9
  } esel_e;

  localparam logic [2:0] ADDR_GCTL = 3'd0;
  localparam logic [2:0] ADDR_OVF  = 3'd1;
  localparam logic [2:0] ADDR_CTL0 = 3'd2;
  localparam logic [2:0] ADDR_VAL0 = 3'd3;

  localparam int GCTL_GEN = 0;
  localparam int GCTL_FRZ = 1;

  localparam int CTL_ESEL_LSB = 0;
  localparam int CTL_EN       = 4;
  localparam int CTL_IE       = 5;
  localparam int CTL_W        = 6;

  // Counter i owns the CTL/VAL register pair starting at address 2+2i.
  function automatic logic [2:0] ctl_addr(int unsigned idx);
    return ADDR_CTL0 + 3'(2 * idx);
  endfunction

  function automatic logic [2:0] val_addr(int unsigned idx);
    return ADDR_VAL0 + 3'(2 * idx);
  endfunction

endpackage

// File: rtl/pcont_perfcnt_ctr.sv
// One counter slice: control register, value register, event mux and the
// single-cycle wrap pulse consumed by the top-level OVF/FRZ logic.
module pcont_perfcnt_ctr
  import pcont_perfcnt_pkg::*;
#(
  parameter int unsigned CW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             gen_i,
  input  logic [15:0]      evt_i,
  input  logic             ctl_we_i,
  input  logic [CTL_W-1:0] ctl_wdata_i,
  input  logic             val_we_i,
  input  logic [CW-1:0]    val_wdata_i,
  output logic [CTL_W-1:0] ctl_o,
  output logic [CW-1:0]    val_o,
  output logic             wrap_o
);

  logic [CTL_W-1:0] ctl_q, ctl_d;
  logic [CW-1:0]    val_q, val_d;
  logic             inc;

  // The registered CTL governs this cycle; a CTL write only affects later cycles.
  assign inc = gen_i & ctl_q[CTL_EN] & evt_i[ctl_q[CTL_ESEL_LSB +: 4]];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    ctl_d  = ctl_q;
    val_d  = val_q;
    wrap_o = 1'b0;
    if (ctl_we_i) ctl_d = ctl_wdata_i;
    // A software write to VAL discards a coincident increment and its wrap.
    if (val_we_i) begin
      val_d = val_wdata_i;
    end else if (inc) begin
      val_d  = val_q + CW'(1);
      wrap_o = &val_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q <= '0;
      val_q <= '0;
    end else begin
      ctl_q <= ctl_d;
      val_q <= val_d;
    end
  end

  assign ctl_o = ctl_q;
  assign val_o = val_q;

endmodule

// File: rtl/pcont_perfcnt.sv
// Performance-counter bank top: global control, sticky overflow status,
// registered read port and the overflow interrupt.
module pcont_perfcnt
  import pcont_perfcnt_pkg::*;
#(
  parameter int unsigned NCNT = 2,
  parameter int unsigned CW   = 32
) (
  input  logic        SYSCLK,
  input  logic        RESET_D2_R_N,
  input  logic        CNTINST_R,
  input  logic        CNTIMISS_R,
  input  logic        CNTISTALL_R,
  input  logic        CNTDMISS_R,
  input  logic        CNTDSTALL_R,
  input  logic        CNTDLOAD_R,
  input  logic        CNTDSTORE_R,
  input  logic        RHOLD,
  input  logic        PC_WE,
  input  logic [2:0]  PC_ADDR,
  input  logic [31:0] PC_WDATA,
  output logic [31:0] PC_RDATA,
  output logic        PC_OVF_INT
);

  logic             gen_q, gen_d, frz_q, frz_d;
  logic [NCNT-1:0]  ovf_q, ovf_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [15:0]      evt_vec;
  logic [NCNT-1:0]  wrap, ie;
  logic [CTL_W-1:0] ctl [NCNT];
  logic [CW-1:0]    val [NCNT];

  always_comb begin
    evt_vec              = '0;
    evt_vec[ESEL_CYCLE]  = ~RHOLD;
    evt_vec[ESEL_INST]   = CNTINST_R;
    evt_vec[ESEL_IMISS]  = CNTIMISS_R;
    evt_vec[ESEL_ISTALL] = CNTISTALL_R;
    evt_vec[ESEL_DMISS]  = CNTDMISS_R;
    evt_vec[ESEL_DSTALL] = CNTDSTALL_R;
    evt_vec[ESEL_DLOAD]  = CNTDLOAD_R;
    evt_vec[ESEL_DSTORE] = CNTDSTORE_R;
    evt_vec[ESEL_DLDST]  = CNTDLOAD_R | CNTDSTORE_R;
  end

  for (genvar g = 0; g < NCNT; g++) begin : g_ctr
    pcont_perfcnt_ctr #(.CW(CW)) u_ctr (
      .clk         (SYSCLK),
      .rst_n       (RESET_D2_R_N),
      .gen_i       (gen_q),
      .evt_i       (evt_vec),
      .ctl_we_i    (PC_WE && (PC_ADDR == ctl_addr(g))),
      .ctl_wdata_i (PC_WDATA[CTL_W-1:0]),
      .val_we_i    (PC_WE && (PC_ADDR == val_addr(g))),
      .val_wdata_i (PC_WDATA[CW-1:0]),
      .ctl_o       (ctl[g]),
      .val_o       (val[g]),
      .wrap_o      (wrap[g])
    );
    assign ie[g] = ctl[g][CTL_IE];
  end

  // Hardware events win over software: FRZ clear beats a GEN write, a new
  // overflow beats a W1C of the same bit.
  always_comb begin
    gen_d = gen_q;
    frz_d = frz_q;
    ovf_d = ovf_q;
    if (PC_WE && (PC_ADDR == ADDR_GCTL)) begin
      gen_d = PC_WDATA[GCTL_GEN];
      frz_d = PC_WDATA[GCTL_FRZ];
    end
    if (frz_q && (|wrap)) gen_d = 1'b0;
    if (PC_WE && (PC_ADDR == ADDR_OVF)) ovf_d = ovf_q & ~PC_WDATA[NCNT-1:0];
    ovf_d = ovf_d | wrap;
  end

  always_comb begin
    rdata_d = '0;
    if (PC_ADDR == ADDR_GCTL) begin
      rdata_d[GCTL_GEN] = gen_q;
      rdata_d[GCTL_FRZ] = frz_q;
    end
    if (PC_ADDR == ADDR_OVF) rdata_d[NCNT-1:0] = ovf_q;
    for (int unsigned i = 0; i < NCNT; i++) begin
      if (PC_ADDR == ctl_addr(i)) rdata_d[CTL_W-1:0] = ctl[i];
      if (PC_ADDR == val_addr(i)) rdata_d[CW-1:0]    = val[i];
    end
  end

  always_ff @(posedge SYSCLK or negedge RESET_D2_R_N) begin
    if (!RESET_D2_R_N) begin
      gen_q   <= 1'b0;
      frz_q   <= 1'b0;
      ovf_q   <= '0;
      rdata_q <= '0;
    end else begin
      gen_q   <= gen_d;
      frz_q   <= frz_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
    end
  end

  assign PC_RDATA   = rdata_q;
  assign PC_OVF_INT = |(ovf_q & ie);

endmodule
